pp_piarb_rr_arb: RTL and testbench

Round-robin arbiter on the consumer side of the per-parser packet-parser→PI-arbiter metadata FIFOs. Each of NUM_PP packet parsers owns one show-ahead FIFO of `pp_piarb_meta_type` entries. This block pops one entry per cycle, choosing fairly among non-empty, enabled sources. It presents the selected entry, tagged with its source index, on a registered valid/ready output toward the PI arbiter core.

---
 rtl/pp_piarb_rr_arb.sv | 126 ++++++++++++
 tb/tb_pp_piarb_rr_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pp_piarb_rr_arb.sv
// Round-robin pop arbiter over NUM_PP show-ahead parser metadata FIFOs, with a registered valid/ready output.
// Optional per-source grant counters are built when PIARB_STATS_EN is defined; otherwise stat_cnt_o is tied to 0.
module pp_piarb_rr_arb #(
    parameter int NUM_PP     = 4,
    parameter int SRC_NBITS  = 2,
    parameter int STAT_NBITS = 32,
    parameter int META_W     = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_PP-1:0]            fifo_empty_i,
    input  logic [NUM_PP*META_W-1:0]     fifo_dout_i,
    output logic [NUM_PP-1:0]            fifo_rd_o,
    input  logic [NUM_PP-1:0]            src_en_i,
    input  logic                         out_ready_i,
    output logic                         out_valid_o,
    output logic [META_W-1:0]            out_meta_o,
    output logic [SRC_NBITS-1:0]         out_src_o,
    output logic [NUM_PP*STAT_NBITS-1:0] stat_cnt_o
);
    localparam int IDXW = SRC_NBITS + 1;

    logic [NUM_PP-1:0]    req;
    logic                 load;
    logic                 win_found;
    logic [SRC_NBITS-1:0] win_idx;
    logic [IDXW-1:0]      cand;
    logic                 grant;

    logic                 out_valid_q, out_valid_d;
    logic [META_W-1:0]    out_meta_q,  out_meta_d;
    logic [SRC_NBITS-1:0] out_src_q,   out_src_d;
    logic [SRC_NBITS-1:0] rr_ptr_q,    rr_ptr_d;

    assign req   = ~fifo_empty_i & src_en_i;
    assign load  = ~out_valid_q | out_ready_i;
    assign grant = load & win_found & ~rst_i;

    // Search starts at rr_ptr and wraps modulo NUM_PP, so non-power-of-2 counts never index past the last source.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PP; k++) begin
            cand = {1'b0, rr_ptr_q} + IDXW'(k);
            if (cand >= IDXW'(NUM_PP))
                cand = cand - IDXW'(NUM_PP);
            if (!win_found && req[cand[SRC_NBITS-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SRC_NBITS-1:0];
            end
        end
    end

    always_comb begin
        fifo_rd_o = '0;
        if (grant)
            fifo_rd_o[win_idx] = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_meta_d  = out_meta_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = win_found;
            if (win_found) begin
                out_meta_d = fifo_dout_i[int'(win_idx)*META_W +: META_W];
                out_src_d  = win_idx;
                rr_ptr_d   = (win_idx == SRC_NBITS'(NUM_PP-1)) ? '0 : win_idx + SRC_NBITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_meta_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_meta_q  <= out_meta_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_meta_o  = out_meta_q;
    assign out_src_o   = out_src_q;

`ifdef PIARB_STATS_EN
    logic [STAT_NBITS-1:0] stat_q [NUM_PP];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PP; i++)
                stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PP; i++)
                if (fifo_rd_o[i])
                    stat_q[i] <= stat_q[i] + STAT_NBITS'(1);
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        for (int i = 0; i < NUM_PP; i++)
            stat_cnt_o[i*STAT_NBITS +: STAT_NBITS] = stat_q[i];
    end
`else
    assign stat_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // Pop sanity: at most one pop per cycle and never from an empty FIFO.
    always_comb begin
        if (!rst_i) begin
            assert ($onehot0(fifo_rd_o));
            assert ((fifo_rd_o & fifo_empty_i) == '0);
        end
    end
`endif
endmodule

// File: tb/tb_pp_piarb_rr_arb.sv
// Randomized bench for pp_piarb_rr_arb: bench-owned FIFO queues plus a round-robin reference model.
module tb_pp_piarb_rr_arb;
    localparam int NUM_PP = 4, SRC_NBITS = 2, STAT_NBITS = 4, META_W = 16;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic [NUM_PP-1:0]            fifo_empty_i;
    logic [NUM_PP*META_W-1:0]     fifo_dout_i;
    logic [NUM_PP-1:0]            fifo_rd_o;
    logic [NUM_PP-1:0]            src_en_i;
    logic                         out_ready_i;
    logic                         out_valid_o;
    logic [META_W-1:0]            out_meta_o;
    logic [SRC_NBITS-1:0]         out_src_o;
    logic [NUM_PP*STAT_NBITS-1:0] stat_cnt_o;

    pp_piarb_rr_arb #(.NUM_PP(NUM_PP), .SRC_NBITS(SRC_NBITS), .STAT_NBITS(STAT_NBITS), .META_W(META_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fifo_empty_i(fifo_empty_i), .fifo_dout_i(fifo_dout_i),
        .fifo_rd_o(fifo_rd_o), .src_en_i(src_en_i), .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
        .out_meta_o(out_meta_o), .out_src_o(out_src_o), .stat_cnt_o(stat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Per-source FIFO contents held by the bench
    bit [META_W-1:0] mem [NUM_PP][256];
    int wp [NUM_PP];
    int rp [NUM_PP];

    // Reference model state
    bit                 m_vld;
    bit [META_W-1:0]    m_meta;
    int                 m_src, m_ptr;
    int                 m_stat [NUM_PP];
    logic [NUM_PP-1:0]  obs_rd, exp_rd;
    int                 exp_win;
    logic [NUM_PP*STAT_NBITS-1:0] exp_stat;
    int n_cmp = 0, n_err = 0;

    task automatic push(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            mem[s][wp[s] % 256] = META_W'($urandom);
            wp[s]++;
        end
    endtask

    // One clock: drive FIFO view, predict pop, clock, then advance the model.
    task automatic cycle();
        for (int i = 0; i < NUM_PP; i++) begin
            fifo_empty_i[i] = (wp[i] == rp[i]);
            fifo_dout_i[i*META_W +: META_W] = mem[i][rp[i] % 256];
        end
        #1;
        exp_rd  = '0;
        exp_win = -1;
        if (!rst_i && (!m_vld || out_ready_i))
            for (int k = 0; k < NUM_PP; k++) begin
                int j;
                j = (m_ptr + k) % NUM_PP;
                if (exp_win < 0 && wp[j] != rp[j] && src_en_i[j]) exp_win = j;
            end
        if (exp_win >= 0) exp_rd[exp_win] = 1'b1;
        obs_rd = fifo_rd_o;
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            m_vld = 0; m_meta = '0; m_src = 0; m_ptr = 0;
            for (int i = 0; i < NUM_PP; i++) begin m_stat[i] = 0; rp[i] = wp[i]; end
        end else if (exp_win >= 0) begin
            m_meta = mem[exp_win][rp[exp_win] % 256];
            rp[exp_win]++;
            m_src = exp_win;
            m_vld = 1;
            m_ptr = (exp_win + 1) % NUM_PP;
`ifdef PIARB_STATS_EN
            m_stat[exp_win] = (m_stat[exp_win] + 1) % (1 << STAT_NBITS);
`endif
        end else if (!m_vld || out_ready_i) begin
            m_vld = 0;
        end
        for (int i = 0; i < NUM_PP; i++)
            exp_stat[i*STAT_NBITS +: STAT_NBITS] = STAT_NBITS'(m_stat[i]);
    endtask

    task automatic test_reset();
        rst_i = 1; out_ready_i = 1; src_en_i = '1;
        for (int i = 0; i < NUM_PP; i++) push(i, 2);
        cycle();
        n_cmp++;
        if (obs_rd !== '0) begin n_err++; $display("FAIL reset_rd got %b want 0", obs_rd); end
        n_cmp++;
        if ({out_valid_o, out_src_o, out_meta_o} !== '0)
            begin n_err++; $display("FAIL reset_out got v=%b s=%0d m=%h want 0", out_valid_o, out_src_o, out_meta_o); end
        n_cmp++;
        if (stat_cnt_o !== '0) begin n_err++; $display("FAIL reset_stat got %h want 0", stat_cnt_o); end
        rst_i = 0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < NUM_PP; i++) push(i, 3);
        for (int c = 0; c < 13; c++) begin
            cycle();
            n_cmp++;
            if (obs_rd !== exp_rd) begin n_err++; $display("FAIL rr_rd c%0d got %b want %b", c, obs_rd, exp_rd); end
            n_cmp++;
            if ({out_valid_o, out_src_o, out_meta_o} !== {m_vld, SRC_NBITS'(m_src), m_meta})
                begin n_err++; $display("FAIL rr_out c%0d got %b/%0d/%h want %b/%0d/%h", c, out_valid_o, out_src_o, out_meta_o, m_vld, m_src, m_meta); end
            n_cmp++;
            if (c < 12 && {out_valid_o, out_src_o} !== {1'b1, SRC_NBITS'(c % NUM_PP)})
                begin n_err++; $display("FAIL rr_order c%0d got v=%b s=%0d want v=1 s=%0d", c, out_valid_o, out_src_o, c % NUM_PP); end
            else if (c == 12 && out_valid_o !== 1'b0)
                begin n_err++; $display("FAIL rr_drop got v=%b want 0", out_valid_o); end
        end
    endtask

    task automatic test_single_src();
        int hits;
        hits = 0;
        push(2, 5);
        for (int c = 0; c < 6; c++) begin
            cycle();
            n_cmp++;
            if ({obs_rd, out_valid_o, out_src_o, out_meta_o} !== {exp_rd, m_vld, SRC_NBITS'(m_src), m_meta})
                begin n_err++; $display("FAIL single c%0d got rd=%b v=%b s=%0d m=%h want rd=%b v=%b s=%0d m=%h", c, obs_rd, out_valid_o, out_src_o, out_meta_o, exp_rd, m_vld, m_src, m_meta); end
            if (out_valid_o && out_src_o == 2) hits++;
        end
        n_cmp++;
        if (hits != 5) begin n_err++; $display("FAIL single_cnt got %0d want 5", hits); end
        n_cmp++;
        if (dut.rr_ptr_q !== 2'd3) begin n_err++; $display("FAIL single_ptr got %0d want 3", dut.rr_ptr_q); end
    endtask

    task automatic test_stall();
        logic [META_W-1:0] held;
        for (int i = 0; i < NUM_PP; i++) push(i, 2);
        out_ready_i = 1;
        cycle();
        held = out_meta_o;
        out_ready_i = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_cmp++;
            if ({obs_rd, out_valid_o, out_meta_o} !== {NUM_PP'(0), 1'b1, held})
                begin n_err++; $display("FAIL stall c%0d got rd=%b v=%b m=%h want rd=0 v=1 m=%h", c, obs_rd, out_valid_o, out_meta_o, held); end
        end
        out_ready_i = 1;
        for (int c = 0; c < 9; c++) begin
            cycle();
            n_cmp++;
            if ({obs_rd, out_valid_o, out_src_o, out_meta_o} !== {exp_rd, m_vld, SRC_NBITS'(m_src), m_meta})
                begin n_err++; $display("FAIL stall_resume c%0d got rd=%b s=%0d m=%h want rd=%b s=%0d m=%h", c, obs_rd, out_src_o, out_meta_o, exp_rd, m_src, m_meta); end
            if (c == 0 && obs_rd === '0) begin n_err++; $display("FAIL stall_regrant got rd=0 want nonzero"); end
        end
    endtask

    task automatic test_src_en();
        for (int i = 0; i < NUM_PP; i++) push(i, 4);
        src_en_i = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) src_en_i = 4'b1011;
            cycle();
            n_cmp++;
            if ({obs_rd, out_valid_o, out_src_o, out_meta_o} !== {exp_rd, m_vld, SRC_NBITS'(m_src), m_meta})
                begin n_err++; $display("FAIL en c%0d got rd=%b s=%0d want rd=%b s=%0d", c, obs_rd, out_src_o, exp_rd, m_src); end
            n_cmp++;
            if (c < 4 && (obs_rd & 4'b0101) !== '0) begin n_err++; $display("FAIL en_mask c%0d got rd=%b want only bits 1,3", c, obs_rd); end
        end
        src_en_i = '1;
        for (int c = 0; c < 12; c++) cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NUM_PP; i++) push(i, 3);
        cycle(); cycle();
        rst_i = 1;
        cycle();
        n_cmp++;
        if ({obs_rd, out_valid_o, dut.rr_ptr_q} !== '0)
            begin n_err++; $display("FAIL rstmid got rd=%b v=%b ptr=%0d want 0", obs_rd, out_valid_o, dut.rr_ptr_q); end
        rst_i = 0;
        push(2, 1); push(3, 1);
        cycle();
        n_cmp++;
        if ({out_valid_o, out_src_o, out_meta_o} !== {1'b1, 2'd2, m_meta})
            begin n_err++; $display("FAIL rstmid_first got v=%b s=%0d m=%h want v=1 s=2 m=%h", out_valid_o, out_src_o, out_meta_o, m_meta); end
        cycle(); cycle();
    endtask

    task automatic test_stats();
        rst_i = 1; cycle(); rst_i = 0;
        push(1, 17);
        for (int c = 0; c < 18; c++) begin
            cycle();
            n_cmp++;
            if (stat_cnt_o !== exp_stat) begin n_err++; $display("FAIL stat c%0d got %h want %h", c, stat_cnt_o, exp_stat); end
        end
        n_cmp++;
`ifdef PIARB_STATS_EN
        if (stat_cnt_o[STAT_NBITS +: STAT_NBITS] !== 4'd1)
`else
        if (stat_cnt_o[STAT_NBITS +: STAT_NBITS] !== 4'd0)
`endif
            begin n_err++; $display("FAIL stat_wrap got %0d", stat_cnt_o[STAT_NBITS +: STAT_NBITS]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            src_en_i    = NUM_PP'($urandom);
            out_ready_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_PP; i++)
                if (wp[i] - rp[i] < 6 && $urandom_range(0, 2) == 0) push(i, 1);
            cycle();
            n_cmp++;
            if ({obs_rd, out_valid_o, out_src_o, out_meta_o, stat_cnt_o} !== {exp_rd, m_vld, SRC_NBITS'(m_src), m_meta, exp_stat})
                begin n_err++; $display("FAIL rand c%0d got rd=%b v=%b s=%0d m=%h st=%h want rd=%b v=%b s=%0d m=%h st=%h",
                    c, obs_rd, out_valid_o, out_src_o, out_meta_o, stat_cnt_o, exp_rd, m_vld, m_src, m_meta, exp_stat); end
        end
    endtask

    initial begin
        rst_i = 1; out_ready_i = 1; src_en_i = '1;
        fifo_empty_i = '1; fifo_dout_i = '0;
        for (int i = 0; i < NUM_PP; i++) begin wp[i] = 0; rp[i] = 0; m_stat[i] = 0; end
        m_vld = 0; m_meta = '0; m_src = 0; m_ptr = 0; exp_stat = '0;
        #2;
        test_reset();
        test_round_robin();
        test_single_src();
        test_stall();
        test_src_en();
        test_reset_mid();
        test_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
